// File: rtl/ha_array_seq_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ha_array_seq_accum: reduces the four HA-array rows into a PW-bit product  |
// | one row per cycle. Optional row skipping: define HA_SEQ_ROW_SKIP_EN.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ha_array_seq_accum #(
   parameter int NROWS = 4,
   parameter int PW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    x,
   input  logic [7:0]    y,
   output logic [7:0]    arr_x,
   output logic [7:0]    arr_y,
   input  logic [8:0]    ha_array_0_t,
   input  logic [8:0]    ha_array_1_t,
   input  logic [8:0]    ha_array_2_t,
   input  logic [8:0]    ha_array_3_t,
   input  logic [6:0]    ha_array_0_b,
   input  logic [6:0]    ha_array_1_b,
   input  logic [6:0]    ha_array_2_b,
   input  logic [6:0]    ha_array_3_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] product,
   output logic          busy
);
   localparam int CW = $clog2(NROWS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   product_q, product_d;
   logic [7:0]      arr_x_q, arr_x_d;
   logic [7:0]      arr_y_q, arr_y_d;
   logic            out_valid_q, out_valid_d;

   logic [8:0]      row_t [NROWS];
   logic [6:0]      row_b [NROWS];
   logic [PW-1:0]   rowval;
   logic [PW-1:0]   contrib;
   logic [CW-1:0]   first_row;
   logic [CW-1:0]   next_row;
   logic            row_en;
   logic            last_row;
   logic            accept;

   assign row_t[0] = ha_array_0_t;
   assign row_t[1] = ha_array_1_t;
   assign row_t[2] = ha_array_2_t;
   assign row_t[3] = ha_array_3_t;
   assign row_b[0] = ha_array_0_b;
   assign row_b[1] = ha_array_1_b;
   assign row_b[2] = ha_array_2_b;
   assign row_b[3] = ha_array_3_b;

   assign accept  = (state_q == IDLE) && in_valid;
   assign rowval  = PW'(row_t[cnt_q]) + (PW'(row_b[cnt_q]) << 2);
   assign contrib = row_en ? (rowval << {cnt_q, 1'b0}) : '0;

`ifdef HA_SEQ_ROW_SKIP_EN
   logic [NROWS-1:0] mask_q, mask_d;
   logic [NROWS-1:0] mask_in;
   logic             has_next;

   // Row r only carries partial products when x[2r+1:2r] is non-zero.
   always_comb begin
      mask_in   = '0;
      first_row = '0;
      next_row  = cnt_q;
      has_next  = 1'b0;
      for (int r = NROWS - 1; r >= 0; r--) begin
         mask_in[r] = |x[2*r +: 2];
         if (mask_in[r]) begin
            first_row = CW'(r);
         end
         if (mask_q[r] && (CW'(r) > cnt_q)) begin
            next_row = CW'(r);
            has_next = 1'b1;
         end
      end
   end

   // An all-zero mask still spends one ACC cycle with a gated contribution.
   assign row_en   = mask_q[cnt_q];
   assign last_row = !has_next;
   assign mask_d   = accept ? mask_in : mask_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end
`else
   assign first_row = '0;
   assign next_row  = cnt_q + CW'(1);
   assign row_en    = 1'b1;
   assign last_row  = (cnt_q == CW'(NROWS - 1));
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      product_d   = product_q;
      arr_x_d     = arr_x_q;
      arr_y_d     = arr_y_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               arr_x_d = x;
               arr_y_d = y;
               acc_d   = '0;
               cnt_d   = first_row;
               state_d = ACC;
            end
         end
         ACC: begin
            acc_d = acc_q + contrib;
            cnt_d = next_row;
            if (last_row) begin
               product_d   = acc_q + contrib;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         product_q   <= '0;
         arr_x_q     <= '0;
         arr_y_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         product_q   <= product_d;
         arr_x_q     <= arr_x_d;
         arr_y_q     <= arr_y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign arr_x     = arr_x_q;
   assign arr_y     = arr_y_q;

endmodule
`default_nettype wire

// File: tb/tb_ha_array_seq_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ha_array_seq_accum: scoreboard bench for ha_array_seq_accum            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ha_array_seq_accum;
`ifdef HA_SEQ_ROW_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      int prod;
      int lat;
      int xv;
      int yv;
      int stamp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  x, y;
   logic [7:0]  arr_x, arr_y;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;
   logic [8:0]  rt [4];
   logic [6:0]  rb [4];
   logic [8:0]  nt [4];
   logic [6:0]  nb [4];

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   rdy_rand = 1'b0;
   exp_t sb[$];

   ha_array_seq_accum #(.NROWS(4), .PW(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .x            (x),
      .y            (y),
      .arr_x        (arr_x),
      .arr_y        (arr_y),
      .ha_array_0_t (rt[0]),
      .ha_array_1_t (rt[1]),
      .ha_array_2_t (rt[2]),
      .ha_array_3_t (rt[3]),
      .ha_array_0_b (rb[0]),
      .ha_array_1_b (rb[1]),
      .ha_array_2_b (rb[2]),
      .ha_array_3_b (rb[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Product = sum of rowval_r * 4^r, modulo 2^16; rows with x pair 00 drop out when skipping.
   function automatic int model_prod(input logic [7:0] xv);
      int s = 0;
      for (int r = 0; r < 4; r++) begin
         if (!SKIP || (xv[2*r +: 2] != 2'b00)) begin
            s += (int'(nt[r]) + 4 * int'(nb[r])) * (1 << (2 * r));
         end
      end
      return s % 65536;
   endfunction

   function automatic int model_lat(input logic [7:0] xv);
      int n = 0;
      if (!SKIP) return 4;
      for (int r = 0; r < 4; r++) begin
         if (xv[2*r +: 2] != 2'b00) n++;
      end
      return (n == 0) ? 1 : n;
   endfunction

   task automatic tick();
      @(negedge clk);
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Called at a negedge; accepts at the following posedge, returns one negedge later.
   task automatic do_op(input logic [7:0] xv, input logic [7:0] yv);
      int   n = 0;
      exp_t e;
      while (!in_ready && n < 200) begin
         in_valid = 1'($urandom_range(0, 1));
         x = 8'($urandom);
         y = 8'($urandom);
         tick();
         n++;
      end
      chk("in_ready_wait", int'(in_ready), 1);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      for (int r = 0; r < 4; r++) begin
         rt[r] = nt[r];
         rb[r] = nb[r];
      end
      x = xv;
      y = yv;
      in_valid = 1'b1;
      e.prod  = model_prod(xv);
      e.lat   = model_lat(xv);
      e.xv    = int'(xv);
      e.yv    = int'(yv);
      e.stamp = cyc;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      x = 8'($urandom);
      y = 8'($urandom);
   endtask

   task automatic set_rows(input int tv, input int bv);
      for (int r = 0; r < 4; r++) begin
         nt[r] = 9'(tv);
         nb[r] = 7'(bv);
      end
   endtask

   // Monitor: pops on each rising out_valid, then checks stability while presented.
   bit          seen = 1'b0;
   logic [15:0] held_p;
   logic [7:0]  held_x;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || !out_valid) begin
         seen = 1'b0;
      end else if (!seen) begin
         seen = 1'b1;
         held_p = product;
         held_x = arr_x;
         if (sb.size() == 0) begin
            chk("unexpected_output_count", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("product", int'(product), e.prod);
            chk("latency", cyc - e.stamp - 1, e.lat);
            chk("arr_x_in_done", int'(arr_x), e.xv);
            chk("arr_y_in_done", int'(arr_y), e.yv);
            chk("in_ready_in_done", int'(in_ready), 0);
            chk("busy_in_done", int'(busy), 1);
         end
      end else begin
         chk("product_stable", int'(product), int'(held_p));
         chk("arr_x_stable", int'(arr_x), int'(held_x));
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      x = '0;
      y = '0;
      set_rows(0, 0);
      for (int r = 0; r < 4; r++) begin
         rt[r] = '0;
         rb[r] = '0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_product", int'(product), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_arr_x", int'(arr_x), 0);
      chk("reset_arr_y", int'(arr_y), 0);

      // Basic sum, wrap and the single-row/zero-operand cases.
      out_ready = 1'b1;
      set_rows(0, 0);
      nt[0] = 9'd1;
      nb[1] = 7'd1;
      do_op(8'h03, 8'h05);
      set_rows(9'h1FF, 7'h7F);
      do_op(8'hFF, 8'hFF);
      set_rows(0, 0);
      nt[3] = 9'd1;
      do_op(8'h40, 8'h11);
      set_rows(9'h1FF, 7'h7F);
      do_op(8'h00, 8'h22);

      // Backpressure with in_valid held high throughout DONE.
      set_rows(37, 5);
      do_op(8'hA5, 8'h3C);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_out_valid_seen", int'(out_valid), 1);
      in_valid = 1'b1;
      x = 8'h5A;
      y = 8'hC3;
      repeat (10) begin
         tick();
         chk("bp_in_ready_low", int'(in_ready), 0);
         chk("bp_out_valid_held", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_accept_next_cycle", int'(in_ready), 1);
      set_rows(100, 3);
      do_op(8'h5A, 8'hC3);

      // Reset two cycles into ACC; the result is discarded.
      set_rows(9'h1FF, 7'h7F);
      do_op(8'hFF, 8'h01);
      tick();
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_product", int'(product), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_arr_x", int'(arr_x), 0);
      chk("midrst_arr_y", int'(arr_y), 0);
      tick();
      rst_n = 1'b1;
      tick();
      set_rows(0, 0);
      nt[1] = 9'd3;
      nb[2] = 7'd2;
      do_op(8'h3C, 8'h77);

      // Randomized operations with random consumer backpressure.
      rdy_rand = 1'b1;
      repeat (40) begin
         for (int r = 0; r < 4; r++) begin
            nt[r] = 9'($urandom_range(0, 511));
            nb[r] = 7'($urandom_range(0, 127));
         end
         n = $urandom_range(0, 2);
         repeat (n) tick();
         do_op(8'($urandom) & 8'($urandom), 8'($urandom));
      end

      rdy_rand = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         tick();
         n++;
      end
      chk("drain_pending", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
